// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the program counter, issues instruction-memory requests,
// buffers one instruction for decode and flags fetch timeouts / misaligned targets.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_vec,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_fetch_err,
    output logic [31:0] o_err_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [7:0]  timer_r, timer_s;
    logic        inst_valid_r, inst_valid_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] inst_pc_r, inst_pc_s;
    logic        fetch_err_r, fetch_err_s;
    logic [31:0] err_pc_r, err_pc_s;
    logic        req_s;
    logic        consume_s;
    logic        unused_s;

    // Trap vectors are word aligned by construction; their low bits are dropped.
    assign unused_s = &{1'b0, i_trap_vec[1:0]};

    // A flush or a stalled full buffer withdraws the request in the same cycle.
    assign req_s     = (state_r == ST_FETCH) & ~(inst_valid_r & i_stall)
                     & ~i_trap_valid & ~i_redirect_valid;
    assign consume_s = inst_valid_r & ~i_stall;

    // Next-state and datapath update, highest-priority source first.
    always_comb begin
        pc_s         = pc_r;
        timer_s      = timer_r;
        inst_valid_s = inst_valid_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        fetch_err_s  = fetch_err_r;
        err_pc_s     = err_pc_r;
        if (state_r == ST_IDLE) begin
            state_s = ST_FETCH;
        end else begin
            state_s = state_r;
        end

        if (i_trap_valid) begin
            pc_s         = {i_trap_vec[31:2], 2'b00};
            inst_valid_s = 1'b0;
            fetch_err_s  = 1'b0;
            timer_s      = 8'd0;
            state_s      = ST_FETCH;
        end else if (i_redirect_valid && (state_r != ST_ERR)) begin
            inst_valid_s = 1'b0;
            if (i_redirect_pc[1:0] == 2'b00) begin
                pc_s    = i_redirect_pc;
                timer_s = 8'd0;
            end else begin
                state_s     = ST_ERR;
                fetch_err_s = 1'b1;
                err_pc_s    = i_redirect_pc;
            end
        end else if (req_s && i_imem_ack) begin
            inst_s       = i_imem_rdata;
            inst_pc_s    = pc_r;
            inst_valid_s = 1'b1;
            pc_s         = pc_r + 32'd4;
            timer_s      = 8'd0;
        end else if (req_s) begin
            if (timer_r == TIMER_LAST) begin
                state_s     = ST_ERR;
                fetch_err_s = 1'b1;
                err_pc_s    = pc_r;
            end else begin
                timer_s = timer_r + 8'd1;
            end
            if (consume_s) begin
                inst_valid_s = 1'b0;
            end else begin
                inst_valid_s = inst_valid_r;
            end
        end else if (consume_s) begin
            inst_valid_s = 1'b0;
        end else begin
            inst_valid_s = inst_valid_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            timer_r      <= 8'd0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
            fetch_err_r  <= 1'b0;
            err_pc_r     <= 32'd0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            timer_r      <= timer_s;
            inst_valid_r <= inst_valid_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
            fetch_err_r  <= fetch_err_s;
            err_pc_r     <= err_pc_s;
        end
    end

    assign o_imem_req   = req_s;
    assign o_imem_addr  = pc_r;
    assign o_pc         = pc_r;
    assign o_inst_valid = inst_valid_r;
    assign o_inst       = inst_r;
    assign o_inst_pc    = inst_pc_r;
    assign o_fetch_err  = fetch_err_r;
    assign o_err_pc     = err_pc_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: scenario tasks plus a scoreboard of fetched
// PCs that is pushed on each accepted request and popped when decode consumes.
module tb_pc_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        i_trap_valid = 1'b0;
    logic [31:0] i_trap_vec = 32'd0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_fetch_err;
    logic [31:0] o_err_pc;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc = 32'd0;
    logic        exp_err = 1'b0;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .i_trap_valid(i_trap_valid), .i_trap_vec(i_trap_vec),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_pc(o_pc), .o_inst_valid(o_inst_valid), .o_inst(o_inst),
        .o_inst_pc(o_inst_pc), .o_fetch_err(o_fetch_err), .o_err_pc(o_err_pc)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign i_imem_rdata = o_imem_req ? mem_word(o_imem_addr) : 32'd0;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard: flush on trap/redirect, pop on consume, push on accepted request.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            sb_q.delete();
            exp_pc = 32'h0000_0000;
        end else if (i_trap_valid) begin
            sb_q.delete();
            exp_pc = {i_trap_vec[31:2], 2'b00};
        end else if (i_redirect_valid && !exp_err) begin
            sb_q.delete();
            if (i_redirect_pc[1:0] == 2'b00) exp_pc = i_redirect_pc;
        end else begin
            if (o_inst_valid && !i_stall) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_underflow: consumed pc %h, none expected", o_inst_pc);
                end else begin
                    logic [31:0] p;
                    p = sb_q.pop_front();
                    if (o_inst_pc !== p || o_inst !== mem_word(p)) begin
                        n_fail++; $display("FAIL sb_inst: got pc %h inst %h, want pc %h inst %h", o_inst_pc, o_inst, p, mem_word(p));
                    end
                end
            end
            if (o_imem_req && i_imem_ack) begin
                n_checks++;
                if (o_imem_addr !== exp_pc) begin
                    n_fail++; $display("FAIL sb_addr: got %h want %h", o_imem_addr, exp_pc);
                end
                sb_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic test_reset();
        repeat (2) cyc();
        n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", o_pc, 32'h0); end
        n_checks++; if (o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_inst_valid); end
        n_checks++; if (o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h/%h want 0/0", o_inst, o_inst_pc); end
        n_checks++; if (o_fetch_err !== 1'b0 || o_err_pc !== 32'h0) begin n_fail++; $display("FAIL reset_err: got %b/%h want 0/0", o_fetch_err, o_err_pc); end
        n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
        i_reset = 1'b1;
        i_imem_ack = 1'b1;
        #1;
        n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", o_imem_req); end
        cyc();
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr: got req %b addr %h want 1 %h", o_imem_req, o_imem_addr, 32'(4 * k)); end
            if (k >= 1) begin
                n_checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL seq_inst_pc: got %b %h want 1 %h", o_inst_valid, o_inst_pc, 32'(4 * (k - 1))); end
            end else begin
                n_checks++; if (o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL seq_first_valid: got %b want 0", o_inst_valid); end
            end
            cyc();
        end
    endtask

    task automatic test_stall();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b want 0", o_imem_req); end
            n_checks++; if (o_inst_pc !== 32'd28 || o_inst !== mem_word(32'd28) || o_pc !== 32'd32) begin n_fail++; $display("FAIL stall_hold: got %h %h %h want %h %h %h", o_inst_pc, o_inst, o_pc, 32'd28, mem_word(32'd28), 32'd32); end
            cyc();
        end
        i_stall = 1'b0;
        #1;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'd32) begin n_fail++; $display("FAIL stall_resume_req: got %b %h want 1 %h", o_imem_req, o_imem_addr, 32'd32); end
        cyc();
        n_checks++; if (o_inst_pc !== 32'd32 || o_pc !== 32'd36) begin n_fail++; $display("FAIL stall_resume: got %h %h want %h %h", o_inst_pc, o_pc, 32'd32, 32'd36); end
    endtask

    task automatic test_redirect();
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h8;
        #1;
        n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", o_imem_req); end
        cyc();
        i_redirect_valid = 1'b0;
        #1;
        cyc();
        n_checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h8) begin n_fail++; $display("FAIL redir_hold8: got %b %h want 1 %h", o_inst_valid, o_inst_pc, 32'h8); end
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h100;
        cyc();
        i_redirect_valid = 1'b0;
        n_checks++; if (o_inst_valid !== 1'b0 || o_pc !== 32'h100) begin n_fail++; $display("FAIL redir_flush: got %b %h want 0 %h", o_inst_valid, o_pc, 32'h100); end
        #1;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %b %h want 1 %h", o_imem_req, o_imem_addr, 32'h100); end
        cyc();
        i_trap_valid = 1'b1; i_trap_vec = 32'h400;
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h300;
        cyc();
        i_trap_valid = 1'b0; i_redirect_valid = 1'b0;
        n_checks++; if (o_pc !== 32'h400 || o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL trap_prio: got %h %b want %h 0", o_pc, o_inst_valid, 32'h400); end
        cyc();
        n_checks++; if (o_inst_pc !== 32'h400 || o_pc !== 32'h404) begin n_fail++; $display("FAIL trap_fetch: got %h %h want %h %h", o_inst_pc, o_pc, 32'h400, 32'h404); end
    endtask

    task automatic test_misaligned();
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h102;
        cyc();
        i_redirect_valid = 1'b0;
        exp_err = 1'b1;
        #1;
        n_checks++; if (o_fetch_err !== 1'b1 || o_err_pc !== 32'h102) begin n_fail++; $display("FAIL mis_err: got %b %h want 1 %h", o_fetch_err, o_err_pc, 32'h102); end
        n_checks++; if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0 || o_pc !== 32'h404) begin n_fail++; $display("FAIL mis_state: got %b %b %h want 0 0 %h", o_imem_req, o_inst_valid, o_pc, 32'h404); end
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h200;
        cyc();
        i_redirect_valid = 1'b0;
        #1;
        n_checks++; if (o_pc !== 32'h404 || o_fetch_err !== 1'b1 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL err_ignore_redir: got %h %b %b want %h 1 0", o_pc, o_fetch_err, o_imem_req, 32'h404); end
        i_trap_valid = 1'b1; i_trap_vec = 32'h203;
        cyc();
        i_trap_valid = 1'b0;
        exp_err = 1'b0;
        i_imem_ack = 1'b0;
        #1;
        n_checks++; if (o_pc !== 32'h200 || o_fetch_err !== 1'b0 || o_imem_req !== 1'b1) begin n_fail++; $display("FAIL trap_recover: got %h %b %b want %h 0 1", o_pc, o_fetch_err, o_imem_req, 32'h200); end
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 15; k++) begin
            cyc();
            n_checks++; if (o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_early_%0d: got %b want 0", k, o_fetch_err); end
        end
        i_imem_ack = 1'b1;
        cyc();
        i_imem_ack = 1'b0;
        n_checks++; if (o_fetch_err !== 1'b0 || o_inst_pc !== 32'h200 || o_pc !== 32'h204) begin n_fail++; $display("FAIL to_late_ack: got %b %h %h want 0 %h %h", o_fetch_err, o_inst_pc, o_pc, 32'h200, 32'h204); end
        for (int k = 1; k <= 16; k++) begin
            #1;
            n_checks++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL to_req_%0d: got %b want 1", k, o_imem_req); end
            cyc();
            if (k < 16) begin
                n_checks++; if (o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_pre_%0d: got %b want 0", k, o_fetch_err); end
            end
        end
        exp_err = 1'b1;
        #1;
        n_checks++; if (o_fetch_err !== 1'b1 || o_err_pc !== 32'h204) begin n_fail++; $display("FAIL to_err: got %b %h want 1 %h", o_fetch_err, o_err_pc, 32'h204); end
        n_checks++; if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL to_state: got %b %b want 0 0", o_imem_req, o_inst_valid); end
    endtask

    task automatic test_wrap();
        i_imem_ack = 1'b1;
        i_trap_valid = 1'b1; i_trap_vec = 32'h500;
        cyc();
        i_trap_valid = 1'b0;
        exp_err = 1'b0;
        i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        cyc();
        i_redirect_valid = 1'b0;
        #1;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %b %h want 1 %h", o_imem_req, o_imem_addr, 32'hFFFF_FFFC); end
        cyc();
        n_checks++; if (o_inst_pc !== 32'hFFFF_FFFC || o_inst !== mem_word(32'hFFFF_FFFC) || o_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_inst: got %h %h %h want %h %h 0", o_inst_pc, o_inst, o_pc, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)); end
        cyc();
        n_checks++; if (o_inst_pc !== 32'h0 || o_pc !== 32'h4) begin n_fail++; $display("FAIL wrap_next: got %h %h want 0 4", o_inst_pc, o_pc); end
    endtask

    task automatic test_reset_mid();
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0700;
        cyc();
        i_redirect_valid = 1'b0;
        i_trap_valid = 1'b0;
        #1;
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0702;
        cyc();
        i_redirect_valid = 1'b0;
        cyc();
        #1;
        i_reset = 1'b0;
        #1;
        n_checks++; if (o_pc !== 32'h0 || o_inst_valid !== 1'b0 || o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h %b %h %h want 0 0 0 0", o_pc, o_inst_valid, o_inst, o_inst_pc); end
        n_checks++; if (o_fetch_err !== 1'b0 || o_err_pc !== 32'h0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b %h %b want 0 0 0", o_fetch_err, o_err_pc, o_imem_req); end
        exp_err = 1'b0;
        cyc();
        i_reset = 1'b1;
        cyc();
        #1;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_resume: got %b %h want 1 0", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 80; k++) begin
            i_stall = ($urandom_range(0, 2) == 0);
            i_imem_ack = ($urandom_range(0, 3) != 0);
            i_redirect_valid = ($urandom_range(0, 15) == 0);
            i_redirect_pc = $urandom() & 32'h0000_0FFC;
            cyc();
        end
        i_redirect_valid = 1'b0; i_stall = 1'b0; i_imem_ack = 1'b1;
        repeat (3) cyc();
        n_checks++; if (o_fetch_err !== 1'b0 || o_inst_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_final: got err %b valid %b want 0 1", o_fetch_err, o_inst_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
